// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with a 2-flop input synchronizer, mid-bit sampling,
// glitch and break rejection, and a one-deep holding register with overrun.
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   input  logic       rx_ready,
   output logic [7:0] rx_out,
   output logic       rx_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            sync1_q, sync1_d;
   logic            rx_sync_q, rx_sync_d;
   logic            done_q, done_d;
   logic [7:0]      rx_out_q, rx_out_d;
   logic            rx_valid_q, rx_valid_d;
   logic            frame_err_q, frame_err_d;
   logic            overrun_q, overrun_d;

   // NOTE: every variable gets a default before the case statement so no path
   // leaves it unassigned; that is what keeps this block free of latches.
   always_comb begin
      sync1_d     = rx;
      rx_sync_d   = sync1_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      done_d      = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
      rx_out_d    = rx_out_q;
      rx_valid_d  = rx_valid_q;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (!rx_sync_q) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_sync_q ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DATA: begin
            if (cnt_q == FULL_M1) begin
               cnt_d          = '0;
               shift_d[idx_q] = rx_sync_q;
               idx_d          = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BREAK: begin
            cnt_d = '0;
            if (rx_sync_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A completed frame is delivered one cycle after the stop-bit sample.
      if (done_q) begin
         if (!rx_valid_q || rx_ready) begin
            rx_out_d   = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
   end

   // NOTE: state uses non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         sync1_q     <= 1'b1;
         rx_sync_q   <= 1'b1;
         done_q      <= 1'b0;
         rx_out_q    <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         sync1_q     <= sync1_d;
         rx_sync_q   <= rx_sync_d;
         done_q      <= done_d;
         rx_out_q    <= rx_out_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign rx_out    = rx_out_q;
   assign rx_valid  = rx_valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule
